// File: rtl/loader_pkg.sv
// Shared types and LEGv8 encoding constants for the instruction loader.
// The VERIFY state exists only when LOADER_VERIFY_EN is defined.
package loader_pkg;

    typedef enum logic [3:0] {
        OpAdds = 4'd0,
        OpSubs = 4'd1,
        OpBr   = 4'd2,
        OpLdur = 4'd3,
        OpStur = 4'd4,
        OpAddi = 4'd5,
        OpCbz  = 4'd6,
        OpBlt  = 4'd7,
        OpB    = 4'd8,
        OpBl   = 4'd9
    } enc_op_t;

    localparam logic [10:0] OpcAdds = 11'b10101011000;
    localparam logic [10:0] OpcSubs = 11'b11101011000;
    localparam logic [10:0] OpcBr   = 11'b11010110000;
    localparam logic [10:0] OpcLdur = 11'b11111000010;
    localparam logic [10:0] OpcStur = 11'b11111000000;
    localparam logic [9:0]  OpcAddi = 10'b1001000100;
    localparam logic [7:0]  OpcCbz  = 8'b10110100;
    localparam logic [7:0]  OpcBlt  = 8'b01010100;
    localparam logic [5:0]  OpcB    = 6'b000101;
    localparam logic [5:0]  OpcBl   = 6'b100101;
    localparam logic [4:0]  CondLt  = 5'b01011;

    typedef enum logic [1:0] {
        StIdle,
`ifdef LOADER_VERIFY_EN
        StVerify,
`endif
        StWrite
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational LEGv8 field packing with immediate range checking.
module instr_pack
    import loader_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rn_i,
    input  logic [4:0]  rm_i,
    input  logic [25:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    logic imm9_ok;
    logic imm19_ok;
    logic imm12_ok;

    // A signed value fits when every bit above the field's sign bit matches it.
    assign imm9_ok  = (&imm_i[25:8]) | ~(|imm_i[25:8]);
    assign imm19_ok = (&imm_i[25:18]) | ~(|imm_i[25:18]);
    assign imm12_ok = ~(|imm_i[25:12]);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (op_i)
            OpAdds: word_o = {OpcAdds, rm_i, 6'b000000, rn_i, rd_i};
            OpSubs: word_o = {OpcSubs, rm_i, 6'b000000, rn_i, rd_i};
            OpBr:   word_o = {OpcBr, 5'b11111, 6'b000000, rn_i, 5'b00000};
            OpLdur: begin
                word_o  = {OpcLdur, imm_i[8:0], 2'b00, rn_i, rd_i};
                legal_o = imm9_ok;
            end
            OpStur: begin
                word_o  = {OpcStur, imm_i[8:0], 2'b00, rn_i, rd_i};
                legal_o = imm9_ok;
            end
            OpAddi: begin
                word_o  = {OpcAddi, imm_i[11:0], rn_i, rd_i};
                legal_o = imm12_ok;
            end
            OpCbz: begin
                word_o  = {OpcCbz, imm_i[18:0], rd_i};
                legal_o = imm19_ok;
            end
            OpBlt: begin
                word_o  = {OpcBlt, imm_i[18:0], CondLt};
                legal_o = imm19_ok;
            end
            OpB:    word_o = {OpcB, imm_i};
            OpBl:   word_o = {OpcBl, imm_i};
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_loader_encoder.sv
// Sequential program loader: encodes requests and fills instruction memory.
// Define LOADER_VERIFY_EN to read back and compare each written word.
module instr_loader_encoder
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [3:0]            in_op_i,
    input  logic [4:0]            in_rd_i,
    input  logic [4:0]            in_rn_i,
    input  logic [4:0]            in_rm_i,
    input  logic [25:0]           in_imm_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    input  logic [31:0]           imem_rdata_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  err_pulse_o,
    output logic                  err_sticky_o
);

    localparam logic [ADDR_WIDTH:0] DepthCnt = DEPTH[ADDR_WIDTH:0];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           word_q, word_d;
    logic                  err_q, err_d;
    logic                  sticky_q, sticky_d;

    logic [31:0] pack_word;
    logic        pack_legal;
    logic        accept;

    instr_pack u_pack (
        .op_i    (in_op_i),
        .rd_i    (in_rd_i),
        .rn_i    (in_rn_i),
        .rm_i    (in_rm_i),
        .imm_i   (in_imm_i),
        .word_o  (pack_word),
        .legal_o (pack_legal)
    );

`ifndef LOADER_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^imem_rdata_i;
`endif

    assign full_o       = (count_q == DepthCnt);
    assign in_ready_o   = (state_q == StIdle) && !full_o;
    assign accept       = in_valid_i && in_ready_o;
    assign count_o      = count_q;
    assign err_pulse_o  = err_q;
    assign err_sticky_o = sticky_q;
    assign imem_addr_o  = addr_q;
    // clear/reset in the WRITE cycle must kill the strobe in that same cycle
    assign imem_we_o    = (state_q == StWrite) && !clear_i && !reset_i;
    assign imem_wdata_o = imem_we_o ? word_q : '0;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        word_d   = word_q;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (pack_legal) begin
                        word_d  = pack_word;
                        addr_d  = count_q[ADDR_WIDTH-1:0];
                        state_d = StWrite;
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                count_d = count_q + 1'b1;
`ifdef LOADER_VERIFY_EN
                state_d = StVerify;
`else
                state_d = StIdle;
`endif
            end
`ifdef LOADER_VERIFY_EN
            StVerify: begin
                state_d = StIdle;
                if (imem_rdata_i != word_q) begin
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
        if (clear_i) begin
            state_d  = StIdle;
            count_d  = '0;
            addr_d   = '0;
            word_d   = '0;
            err_d    = 1'b0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            count_q  <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

endmodule
